// File: rtl/modulo_ps2_tx_if.sv
// Host-side request/response bundle for the PS/2 host-to-device transmitter.
// master: the processor side that issues command bytes; slave: the transmitter.
interface modulo_ps2_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_valid, tx_data, input tx_ready, tx_done, tx_error);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx_done, tx_error);
endinterface

// File: rtl/modulo_ps2_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a request-to-send,
// then shifts {stop, odd parity, byte} out LSB first on device clock falls and
// checks the device ACK. Both PS/2 lines are open-drain (oe=1 pulls low).
// Optional macro PS2_TX_RETRY_EN: retry NACK/timeout up to MAX_RETRY times
// with the same byte before reporting tx_error.
module modulo_ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  modulo_ps2_tx_if.slave tx,
  output logic           rx_inhibit,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);
  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  // cnt_q clears the cycle after the fall is seen, so this lands FAIL exactly
  // TIMEOUT_CYCLES cycles after the fall.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK_SAMPLE, S_WAIT_IDLE, S_FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   sync_clk, sync_data, fall;
  logic [7:0]             data_q, data_d;
  logic [9:0]             frame_q, frame_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   data_oe_q, data_oe_d;
  logic                   ready, done, error, clk_oe, data_oe;

`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~sync_clk;

  // Synchronise the asynchronous pin levels; idle bus level is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= SYNC_STAGES'({clk_sync_q, ps2_clk_in});
      data_sync_q <= SYNC_STAGES'({data_sync_q, ps2_data_in});
      clk_prev_q  <= sync_clk;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      data_oe_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      data_oe_q   <= data_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  // Next-state logic and outputs; line drives depend on state so reset releases them at once.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q + CW'(1);
    data_oe_d = data_oe_q;
    ready     = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    clk_oe    = 1'b0;
    data_oe   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (tx.tx_valid) begin
          data_d  = tx.tx_data;
          cnt_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_cnt_d = '0;
`endif
        end
      end
      S_INHIBIT: begin
        clk_oe = 1'b1;
        if (cnt_q == INH_LAST) state_d = S_REQ;
      end
      S_REQ: begin
        clk_oe    = 1'b1;
        data_oe   = 1'b1;
        cnt_d     = '0;
        frame_d   = {1'b1, ~^data_q, data_q};
        bit_cnt_d = '0;
        data_oe_d = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        data_oe = data_oe_q;
        if (fall) begin
          cnt_d     = '0;
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b1, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // The 10th fall puts the stop bit; the ACK is read on the next fall.
          if (bit_cnt_q == 4'd9) state_d = S_ACK_SAMPLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAIL;
        end
      end
      S_ACK_SAMPLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = sync_data ? S_FAIL : S_WAIT_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAIL;
        end
      end
      S_WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAIL;
        end
      end
      S_FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (retry_cnt_q < RW'(MAX_RETRY)) begin
          retry_cnt_d = retry_cnt_q + RW'(1);
          cnt_d       = '0;
          state_d     = S_INHIBIT;
        end else begin
          error   = 1'b1;
          state_d = S_IDLE;
        end
`else
        error   = 1'b1;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx.tx_ready  = ready;
  assign tx.tx_done   = done;
  assign tx.tx_error  = error;
  assign rx_inhibit   = (state_q != S_IDLE);
  assign ps2_clk_oe   = clk_oe;
  assign ps2_data_oe  = data_oe;
endmodule

// File: tb/tb_modulo_ps2_tx.sv
// Bench for modulo_ps2_tx: behavioural PS/2 device on open-drain lines,
// expected frames queued at send time and compared when the device has clocked them in.
module tb_modulo_ps2_tx;
  localparam int INH  = 10;
  localparam int TMO  = 2000;
  localparam int SYNC = 2;
  localparam int HALF = 30;   // device clock half period in board clocks

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, rx_inhibit;

  modulo_ps2_tx_if bus ();

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  modulo_ps2_tx #(
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC), .MAX_RETRY(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tx(bus), .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #10 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, inh_phases = 0, last_inh_len = 0;
  int err_cyc = 0, fall_cyc = 0;
  logic err_clk_oe = 1'b0, err_data_oe = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Passive monitor: pulse counts and INHIBIT phase lengths.
  always @(negedge clock) begin
    if (bus.tx_done) done_cnt <= done_cnt + 1;
    if (bus.tx_error) begin
      err_cnt     <= err_cnt + 1;
      err_cyc     <= cyc;
      err_clk_oe  <= ps2_clk_oe;
      err_data_oe <= ps2_data_oe;
    end
    if (bus.tx_done && bus.tx_error) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin
      inh_phases   <= inh_phases + 1;
      last_inh_len <= inh_run;
      inh_run      <= 0;
    end
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  task automatic host_send(input logic [7:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 5000) begin @(negedge clock); n++; end
    vectors++;
    if (bus.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: tx_ready=%b required 1", bus.tx_ready);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clock);
    bus.tx_valid = 1'b0;
  endtask

  // Device: wait for start bit with CLK released, then give nclk clocks,
  // sampling DATA on each rising edge; optionally ACK on the 11th clock.
  task automatic dev_frame(input int nclk, input bit ack, output logic [9:0] got);
    int n = 0;
    got = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 300) begin @(negedge clock); n++; end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL start_bit: clk_oe=%b data_oe=%b required 0/1", ps2_clk_oe, ps2_data_oe);
    end else begin
      for (int i = 0; i < nclk; i++) begin
        if (i == 10 && ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clock);
        dev_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clock);
        dev_clk = 1'b1;
        if (i < 10) got[i] = ps2_data_in;
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++;
    if ({bus.tx_ready, bus.tx_done, bus.tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_state: rdy/done/err/inh/coe/doe=%b%b%b%b%b%b required 100000",
               bus.tx_ready, bus.tx_done, bus.tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_send_ed();
    logic [9:0] got, exp;
    int d0 = done_cnt, e0 = err_cnt, p0 = inh_phases;
    exp_q.push_back(frame_of(8'hED));
    fork
      host_send(8'hED);
      dev_frame(11, 1'b1, got);
    join
    repeat (20) @(negedge clock);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL frame_ed: got=%b required %b", got, exp); end
    vectors++;
    if (last_inh_len !== INH || inh_phases !== p0 + 1) begin
      miscompares++;
      $display("FAIL inhibit_len: len=%0d phases=%0d required %0d/%0d", last_inh_len, inh_phases - p0, INH, 1);
    end
    vectors++;
    if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
      miscompares++;
      $display("FAIL done_ed: done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if (rx_inhibit !== 1'b0 || bus.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_ed: rx_inhibit=%b tx_ready=%b required 0/1", rx_inhibit, bus.tx_ready);
    end
  endtask

  task automatic test_parity();
    logic [9:0] got, exp;
    int d0 = done_cnt, p0 = inh_phases;
    exp_q.push_back(frame_of(8'h01));
    fork
      host_send(8'h01);
      dev_frame(11, 1'b1, got);
    join
    repeat (20) @(negedge clock);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    vectors++;
    if (got !== exp || got[8] !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_01: got=%b required %b", got, exp);
    end
    exp_q.push_back(frame_of(8'hFF));
    fork
      host_send(8'hFF);
      dev_frame(11, 1'b1, got);
      begin
        repeat (150) @(negedge clock);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h55;
        @(negedge clock);
        bus.tx_valid = 1'b0;
      end
    join
    repeat (100) @(negedge clock);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    vectors++;
    if (got !== exp || got[8] !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_ff: got=%b required %b", got, exp);
    end
    vectors++;
    if (done_cnt !== d0 + 2 || inh_phases !== p0 + 2) begin
      miscompares++;
      $display("FAIL busy_ignore: done=%0d phases=%0d required 2/2", done_cnt - d0, inh_phases - p0);
    end
  endtask

`ifndef PS2_TX_RETRY_EN
  task automatic test_nack();
    logic [9:0] got, exp;
    int d0 = done_cnt, e0 = err_cnt;
    exp_q.push_back(frame_of(8'h3C));
    fork
      host_send(8'h3C);
      dev_frame(11, 1'b0, got);
    join
    repeat (20) @(negedge clock);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL frame_nack: got=%b required %b", got, exp); end
    vectors++;
    if (err_cnt !== e0 + 1 || done_cnt !== d0 || bus.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nack_result: err=%0d done=%0d rdy=%b required 1/0/1", err_cnt - e0, done_cnt - d0, bus.tx_ready);
    end
  endtask
`else
  task automatic test_retry();
    logic [9:0] got, exp;
    int d0 = done_cnt, e0 = err_cnt, p0 = inh_phases;
    for (int k = 0; k < 3; k++) exp_q.push_back(frame_of(8'h96));
    fork
      host_send(8'h96);
      for (int k = 0; k < 3; k++) begin
        dev_frame(11, (k == 2), got);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL frame_retry%0d: got=%b required %b", k, got, exp);
        end
      end
      begin
        repeat (100) @(negedge clock);
        bus.tx_valid = 1'b1; bus.tx_data = 8'h11;
        @(negedge clock);
        bus.tx_valid = 1'b0;
      end
    join
    repeat (100) @(negedge clock);
    vectors++;
    if (inh_phases !== p0 + 3 || done_cnt !== d0 + 1 || err_cnt !== e0) begin
      miscompares++;
      $display("FAIL retry_result: phases=%0d done=%0d err=%0d required 3/1/0",
               inh_phases - p0, done_cnt - d0, err_cnt - e0);
    end
  endtask
`endif

  task automatic test_timeout();
    logic [9:0] got;
    int d0 = done_cnt, e0 = err_cnt, n = 0;
    fork
      host_send(8'hA5);
      dev_frame(4, 1'b0, got);
    join
    while (err_cnt == e0 && n < TMO * 4) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    // Pin fall -> SYNC flops -> fall strobe, then TMO cycles to the error pulse.
    vectors++;
    if (err_cnt !== e0 + 1 || err_cyc - fall_cyc !== TMO + SYNC) begin
      miscompares++;
      $display("FAIL timeout_delay: err=%0d delay=%0d required 1/%0d", err_cnt - e0, err_cyc - fall_cyc, TMO + SYNC);
    end
    vectors++;
    if (err_clk_oe !== 1'b0 || err_data_oe !== 1'b0 || done_cnt !== d0) begin
      miscompares++;
      $display("FAIL timeout_release: clk_oe=%b data_oe=%b done=%0d required 0/0/0", err_clk_oe, err_data_oe, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] got;
    int d0 = done_cnt, e0 = err_cnt;
    fork
      host_send(8'h00);
      dev_frame(6, 1'b0, got);
    join
    @(negedge clock);
    vectors++;
    if (ps2_data_oe !== 1'b1 || rx_inhibit !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame_drive: data_oe=%b rx_inhibit=%b required 1/1", ps2_data_oe, rx_inhibit);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || bus.tx_ready !== 1'b1 || rx_inhibit !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: coe=%b doe=%b rdy=%b inh=%b required 0/0/1/0",
               ps2_clk_oe, ps2_data_oe, bus.tx_ready, rx_inhibit);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (50) @(negedge clock);
    vectors++;
    if (done_cnt !== d0 || err_cnt !== e0 || bus.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_pulse: done=%0d err=%0d rdy=%b required 0/0/1", done_cnt - d0, err_cnt - e0, bus.tx_ready);
    end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    test_reset();
    test_send_ed();
    test_parity();
`ifndef PS2_TX_RETRY_EN
    test_nack();
`else
    test_retry();
`endif
    test_timeout();
    test_reset_mid_frame();
    vectors++;
    if (both_cnt !== 0 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL exclusive_pulses: both=%0d leftover=%0d required 0/0", both_cnt, exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
